irq_ctrl: RTL and testbench

- Programmable interrupt controller upstream of the MIPS core; drives the core's single `interrupter` input, which is consumed by CP0.
- Synchronises up to N_SRC asynchronous device lines, latches them as pending, masks them, and selects the highest-priority one.
- Presents a single request with a claim/complete handshake.
- Software-visible registers sit on a small word-addressed bus slice decoded from the core's memory interface.

---
 rtl/irq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises N_SRC device lines, latches/masks them, requests CP0 with ack/EOI; pending->interrupter 1 cycle.
// Optional nested preemption with a 4-deep id stack when IRQ_NEST_EN is defined.
module irq_ctrl #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             bus_sel,
    input  logic             bus_ren,
    input  logic             bus_wen,
    input  logic [1:0]       bus_addr,
    input  logic [31:0]      bus_din,
    output logic [31:0]      bus_dout,
    input  logic             intr_ack,
    output logic             interrupter,
    output logic [4:0]       irq_id
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_MODE    = 2'd2;
    localparam logic [1:0] A_CLAIM   = 2'd3;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] s_prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] din_n;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;
    logic [1:0]       state;
    logic [4:0]       winner;
    logic             any_elig;
    logic             preempt;
    logic             take;
    logic             eoi;
    logic             wr_pending;
    logic             wr_mask;
    logic             wr_mode;
    logic             wr_claim;
    logic [31:0]      rd_val;
    logic             unused_bits;

`ifdef IRQ_NEST_EN
    logic [4:0]       stack [4];
    logic [2:0]       sp;
`endif

    assign unused_bits = ^bus_din;
    assign din_n       = bus_din[N_SRC-1:0];
    assign s           = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            s_prev <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            s_prev <= s;
        end
    end

    assign wr_pending = bus_sel & bus_wen & (bus_addr == A_PENDING);
    assign wr_mask    = bus_sel & bus_wen & (bus_addr == A_MASK);
    assign wr_mode    = bus_sel & bus_wen & (bus_addr == A_MODE);
    assign wr_claim   = bus_sel & bus_wen & (bus_addr == A_CLAIM);

    assign elig     = pending & mask;
    assign any_elig = |elig;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = 5'(i);
            end
        end
    end

`ifdef IRQ_NEST_EN
    assign preempt = (state == ST_SERVICE) && any_elig && (winner < irq_id) && (sp != 3'd4);
`else
    assign preempt = 1'b0;
`endif

    assign interrupter = (state == ST_REQ) | preempt;
    // The ack is judged against the pre-write eligible vector of this cycle.
    assign take = intr_ack & any_elig & ((state == ST_REQ) | preempt);
    assign eoi  = wr_claim & (state == ST_SERVICE) & (bus_din[4:0] == irq_id);

    always_comb begin
        w1c     = wr_pending ? din_n : '0;
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (take && (winner == 5'(i))) begin
                ack_clr[i] = mode[i];
            end
        end
    end

    // Edge bits: a fresh rising edge beats W1C/ack clear; a MODE change wipes the bit regardless.
    always_comb begin
        pend_nxt = pending;
        for (int i = 0; i < N_SRC; i++) begin
            if (!mode[i]) begin
                pend_nxt[i] = s[i];
            end else begin
                if (w1c[i] || ack_clr[i]) begin
                    pend_nxt[i] = 1'b0;
                end
                if (s[i] && !s_prev[i]) begin
                    pend_nxt[i] = 1'b1;
                end
            end
        end
        if (wr_mode) begin
            pend_nxt = pend_nxt & ~(din_n ^ mode);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
        end else begin
            pending <= pend_nxt;
            if (wr_mask) begin
                mask <= din_n;
            end
            if (wr_mode) begin
                mode <= din_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            irq_id <= '0;
`ifdef IRQ_NEST_EN
            sp     <= '0;
            for (int j = 0; j < 4; j++) begin
                stack[j] <= '0;
            end
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (take) begin
                        irq_id <= winner;
                        state  <= ST_SERVICE;
                    end else if (!any_elig) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
`ifdef IRQ_NEST_EN
                    // A preempting ack takes precedence over an EOI in the same cycle.
                    if (take) begin
                        stack[sp[1:0]] <= irq_id;
                        sp             <= sp + 3'd1;
                        irq_id         <= winner;
                    end else if (eoi) begin
                        if (sp != 3'd0) begin
                            irq_id <= stack[sp[1:0] - 2'd1];
                            sp     <= sp - 3'd1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
`else
                    if (eoi) begin
                        state <= ST_IDLE;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus_addr)
            A_PENDING: rd_val[N_SRC-1:0] = pending;
            A_MASK:    rd_val[N_SRC-1:0] = mask;
            A_MODE:    rd_val[N_SRC-1:0] = mode;
            default:   rd_val = (state == ST_SERVICE) ? {27'b0, irq_id} : 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_dout <= '0;
        end else if (bus_sel && bus_ren) begin
            bus_dout <= rd_val;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table, hand-written corner sequences, randomized edge-mode traffic.
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        bus_sel = 1'b0;
    logic        bus_ren = 1'b0;
    logic        bus_wen = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic [31:0] bus_din = '0;
    logic [31:0] bus_dout;
    logic        intr_ack = 1'b0;
    logic        interrupter;
    logic [4:0]  irq_id;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_MODE    = 2'd2;
    localparam logic [1:0] A_CLAIM   = 2'd3;

    irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .bus_sel(bus_sel), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
        .intr_ack(intr_ack), .interrupter(interrupter), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] src;
        logic [7:0] mask;
        logic [7:0] exp_pend;
        logic       exp_intr;
        logic [4:0] exp_id;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus_sel = 1'b1; bus_wen = 1'b1; bus_addr = a; bus_din = d;
        tick();
        bus_sel = 1'b0; bus_wen = 1'b0; bus_din = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        bus_sel = 1'b1; bus_ren = 1'b1; bus_addr = a;
        tick();
        d = bus_dout;
        bus_sel = 1'b0; bus_ren = 1'b0;
    endtask

    task automatic do_ack();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
    endtask

    task automatic wait_intr(input string name, input int budget);
        int n;
        n = 0;
        while (!interrupter && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(interrupter), 32'd1);
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    vec_t vecs [6];
    logic [31:0] rd;
    logic [7:0]  mpend;
    logic [7:0]  r, m, w;
    int          exp_id;
    int          guard;

    initial begin
        vecs[0] = '{src: 8'h04, mask: 8'h00, exp_pend: 8'h04, exp_intr: 1'b0, exp_id: 5'd0};
        vecs[1] = '{src: 8'h04, mask: 8'hFF, exp_pend: 8'h04, exp_intr: 1'b1, exp_id: 5'd2};
        vecs[2] = '{src: 8'h22, mask: 8'hFF, exp_pend: 8'h22, exp_intr: 1'b1, exp_id: 5'd1};
        vecs[3] = '{src: 8'h22, mask: 8'hF0, exp_pend: 8'h22, exp_intr: 1'b1, exp_id: 5'd5};
        vecs[4] = '{src: 8'h81, mask: 8'h80, exp_pend: 8'h81, exp_intr: 1'b1, exp_id: 5'd7};
        vecs[5] = '{src: 8'hF0, mask: 8'h0F, exp_pend: 8'hF0, exp_intr: 1'b0, exp_id: 5'd0};

        ticks(3);
        check("rst_interrupter", 32'(interrupter), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        check("rst_bus_dout", bus_dout, 32'd0);
        rst = 1'b0;
        tick();
        bus_rd(A_MASK, rd);
        check("rst_mask", rd, 32'd0);
        bus_rd(A_MODE, rd);
        check("rst_mode", rd, 32'd0);

        // Level-mode vector table
        for (int v = 0; v < 6; v++) begin
            irq_src = 8'h00;
            ticks(4);
            bus_wr(A_MASK, {24'b0, vecs[v].mask});
            irq_src = vecs[v].src;
            ticks(4);
            bus_rd(A_PENDING, rd);
            check($sformatf("vec%0d_pending", v), rd, {24'b0, vecs[v].exp_pend});
            check($sformatf("vec%0d_interrupter", v), 32'(interrupter), 32'(vecs[v].exp_intr));
            if (vecs[v].exp_intr) begin
                do_ack();
                check($sformatf("vec%0d_intr_after_ack", v), 32'(interrupter), 32'd0);
                check($sformatf("vec%0d_irq_id", v), 32'(irq_id), 32'(vecs[v].exp_id));
                bus_rd(A_CLAIM, rd);
                check($sformatf("vec%0d_claim", v), rd, 32'(vecs[v].exp_id));
                irq_src = 8'h00;
                ticks(4);
                bus_wr(A_CLAIM, 32'(vecs[v].exp_id));
            end
            bus_rd(A_CLAIM, rd);
            check($sformatf("vec%0d_claim_idle", v), rd, 32'hFFFF_FFFF);
        end

        // Request latency: irq_src before edge k -> interrupter after edge k+3
        irq_src = 8'h00;
        ticks(4);
        bus_wr(A_MASK, 32'hFF);
        irq_src = 8'h04;
        ticks(3);
        check("lat_k2_low", 32'(interrupter), 32'd0);
        tick();
        check("lat_k3_high", 32'(interrupter), 32'd1);
        do_ack();
        check("lat_irq_id", 32'(irq_id), 32'd2);
        irq_src = 8'h00;
        ticks(4);
        bus_wr(A_CLAIM, 32'd2);

        // Simultaneous write+read returns the old value
        bus_sel = 1'b1; bus_wen = 1'b1; bus_ren = 1'b1; bus_addr = A_MASK; bus_din = 32'h3C;
        tick();
        bus_sel = 1'b0; bus_wen = 1'b0; bus_ren = 1'b0;
        check("rw_same_cycle", bus_dout, 32'hFF);
        bus_rd(A_MASK, rd);
        check("mask_written", rd, 32'h3C);

        // MODE change clears PENDING; edge set beats same-cycle W1C
        bus_wr(A_MASK, 32'h00);
        irq_src = 8'h08;
        ticks(4);
        bus_wr(A_MODE, 32'h08);
        bus_rd(A_PENDING, rd);
        check("mode_change_clears", rd, 32'h0);
        irq_src = 8'h00;
        ticks(3);
        irq_src = 8'h08;
        ticks(2);
        bus_wr(A_PENDING, 32'h08);
        bus_rd(A_PENDING, rd);
        check("set_beats_w1c", rd, 32'h08);
        bus_wr(A_PENDING, 32'h08);
        bus_rd(A_PENDING, rd);
        check("w1c_clears", rd, 32'h0);
        irq_src = 8'h00;
        ticks(3);

        // Two edges in one cycle: priority order 1 then 5
        bus_wr(A_MODE, 32'hFF);
        bus_wr(A_MASK, 32'hFF);
        irq_src = 8'h22;
        tick();
        irq_src = 8'h00;
        wait_intr("edge_req1", 10);
        do_ack();
        check("edge_first_id", 32'(irq_id), 32'd1);
        bus_wr(A_CLAIM, 32'd1);
        wait_intr("edge_req2", 10);
        do_ack();
        check("edge_second_id", 32'(irq_id), 32'd5);
        bus_wr(A_CLAIM, 32'd5);
        bus_rd(A_PENDING, rd);
        check("edge_pending_empty", rd, 32'h0);

        // Mask-out in REQ withdraws the request; mismatched EOI ignored
        bus_wr(A_MODE, 32'h00);
        irq_src = 8'h04;
        wait_intr("req_masked_pre", 10);
        bus_wr(A_MASK, 32'h00);
        tick();
        check("req_withdrawn", 32'(interrupter), 32'd0);
        bus_rd(A_CLAIM, rd);
        check("req_withdrawn_claim", rd, 32'hFFFF_FFFF);
        bus_wr(A_MASK, 32'hFF);
        wait_intr("req_again", 10);
        do_ack();
        check("svc_id2", 32'(irq_id), 32'd2);
        bus_wr(A_CLAIM, 32'd7);
        bus_rd(A_CLAIM, rd);
        check("bad_eoi_ignored", rd, 32'd2);
        do_ack();
        check("ack_in_service_ignored", 32'(irq_id), 32'd2);
        irq_src = 8'h00;
        ticks(3);
        bus_wr(A_CLAIM, 32'd2);
        bus_rd(A_CLAIM, rd);
        check("eoi_to_idle", rd, 32'hFFFF_FFFF);

        // Higher-priority source while servicing id 4
        irq_src = 8'h10;
        wait_intr("nest_req4", 10);
        do_ack();
        check("nest_id4", 32'(irq_id), 32'd4);
        irq_src = 8'h11;
        ticks(4);
`ifdef IRQ_NEST_EN
        check("nest_preempt_req", 32'(interrupter), 32'd1);
        do_ack();
        check("nest_id0", 32'(irq_id), 32'd0);
        irq_src = 8'h10;
        ticks(4);
        bus_wr(A_CLAIM, 32'd0);
        check("nest_pop_id", 32'(irq_id), 32'd4);
        bus_rd(A_CLAIM, rd);
        check("nest_pop_claim", rd, 32'd4);
        check("nest_no_rereq", 32'(interrupter), 32'd0);
`else
        check("no_nest_intr_low", 32'(interrupter), 32'd0);
        check("no_nest_id", 32'(irq_id), 32'd4);
        irq_src = 8'h10;
        ticks(4);
        bus_rd(A_CLAIM, rd);
        check("no_nest_claim", rd, 32'd4);
`endif
        irq_src = 8'h00;
        ticks(4);
        bus_wr(A_CLAIM, 32'd4);
        bus_rd(A_CLAIM, rd);
        check("nest_final_idle", rd, 32'hFFFF_FFFF);

        // Asynchronous reset mid-service
        irq_src = 8'h04;
        wait_intr("rst_svc_req", 10);
        do_ack();
        rst = 1'b1;
        #2;
        check("rst_mid_intr", 32'(interrupter), 32'd0);
        check("rst_mid_id", 32'(irq_id), 32'd0);
        check("rst_mid_dout", bus_dout, 32'd0);
        irq_src = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        bus_rd(A_CLAIM, rd);
        check("rst_mid_claim", rd, 32'hFFFF_FFFF);
        bus_rd(A_MASK, rd);
        check("rst_mid_mask", rd, 32'h0);

        // Randomized edge-mode traffic against a set-of-outstanding-events model
        bus_wr(A_MODE, 32'hFF);
        mpend = 8'h00;
        for (int it = 0; it < 24; it++) begin
            r = 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 255));
            bus_wr(A_MASK, {24'b0, m});
            irq_src = r;
            tick();
            irq_src = 8'h00;
            ticks(3);
            mpend = mpend | r;
            w = 8'($urandom_range(0, 255)) & ~m;
            bus_wr(A_PENDING, {24'b0, w});
            mpend = mpend & ~w;
            bus_rd(A_PENDING, rd);
            check($sformatf("rnd%0d_pending", it), rd, {24'b0, mpend});
            guard = 0;
            while ((mpend & m) != 8'h00 && guard < 9) begin
                exp_id = lowest(mpend & m);
                wait_intr($sformatf("rnd%0d_req", it), 10);
                do_ack();
                check($sformatf("rnd%0d_id", it), 32'(irq_id), 32'(exp_id));
                mpend[exp_id] = 1'b0;
                bus_wr(A_CLAIM, 32'(exp_id));
                guard++;
            end
            ticks(2);
            check($sformatf("rnd%0d_quiet", it), 32'(interrupter), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
